wash_sequencer: RTL
===================

# wash_sequencer

Main program sequencer of the washing machine. Owns the top-level machine state and the 26-bit remaining-time message that the display/LED view logic decodes. Loads a selected program's per-stage durations, counts them down stage by stage on a slow time base, and handles power, start/pause, fault and finish behaviour.

## Interface

Parameters:
- `SEC_PER_UNIT`, default 60: `tick` strobes per one-unit decrement of a stage field.
- `FINISH_SEC`, default 10: `tick` strobes spent in finishST before shutdown.

Ports:
- `cp`  in  1  system clock, all logic rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `tick`  in  1  one-cycle time-base strobe (1 Hz nominal).
- `powerKey`  in  1  one-cycle debounced power press.
- `startKey`  in  1  one-cycle debounced start/pause press.
- `fault`  in  1  level; door open or water fault.
- `sourceData`  in  26  selected program durations, same field layout as `msg`.
- `state`  out  3  machine state: shutDownST=0, beginST=1, setST=2, runST=3, errorST=4, pauseST=5, finishST=6.
- `msg`  out  26  remaining units per stage: F7=[25:23], F6=[22:19], F5=[18:16], F4=[15:13], F3=[12:10], F2=[9:6], F1=[5:3], F0=[2:0].
- `motorOn`  out  1  high exactly when state==runST.
- `buzzer`  out  1  high exactly when state==finishST or state==errorST.

## Operation

- Reset: state=shutDownST, msg=0, prescaler=0, finish counter=0; `motorOn`=0, `buzzer`=0.
- Event priority within one cycle: reset > powerKey > fault > startKey > tick.
- powerKey: shutDownST -> beginST; any other state -> shutDownST with msg=0, counters=0.
- beginST: startKey -> setST.
- setST: msg ignored (held 0). startKey with sourceData!=0 -> runST, msg<=sourceData, prescaler<=0. startKey with sourceData==0 -> stay in setST.
- runST:
  - fault=1 -> errorST (msg, prescaler frozen).
  - startKey -> pauseST (frozen).
  - tick: prescaler increments; on prescaler==SEC_PER_UNIT-1, prescaler<=0 and the active field (highest-numbered nonzero field, F7 first down to F0) decrements by 1.
  - Only one field decrements per event; fields never wrap below 0; other fields unchanged.
  - When the decrement leaves msg==0 -> finishST in the same update, finish counter<=0.
- pauseST: startKey -> runST (resume, prescaler kept); fault=1 -> errorST.
- errorST: startKey while fault==0 -> runST (resume, prescaler kept); startKey while fault==1 ignored.
- finishST: msg==0; each tick increments finish counter; on count reaching FINISH_SEC-1 -> shutDownST.
- Unused encoding 7: next cycle -> shutDownST, msg=0.
- fault, startKey, tick have no effect in shutDownST; tick has no effect outside runST/finishST.

## Timing

- All outputs registered; `state`/`msg` update on the `cp` edge sampling the causing event; `motorOn`/`buzzer` decoded from registered state (same cycle as `state`).
- Key-to-state latency: 1 cycle.
- Field decrement visible on the edge sampling the SEC_PER_UNIT-th tick since load/last decrement (excluding ticks in pause/error).
- Run-to-finish: sum of sourceData fields × SEC_PER_UNIT run-ticks.
- reset asserted mid-run: outputs to reset values immediately (asynchronous), held until deassert; first transition on first edge after deassert.
- powerKey coincident with tick decrement: power wins, msg=0.
- fault coincident with final decrement: errorST entered, msg keeps its pre-decrement value.

## Test plan

- Reset mid-run with msg=0x0000009 -> state=0, msg=0, motorOn=0 asynchronously, before next `cp` edge.
- SEC_PER_UNIT=2: power, start, load sourceData with F7=1, F0=2 -> F7 reaches 0 after 2 ticks, F0 reaches 0 after 6, state=6 on that edge, buzzer=1; after FINISH_SEC ticks state=0.
- setST with sourceData=0, startKey -> state stays 2, msg=0.
- runST, startKey, 5 ticks, startKey -> state 3->5->3, msg and prescaler unchanged across pause.
- fault=1 in runST -> state=4, buzzer=1; startKey with fault=1 -> stays 4; fault=0 then startKey -> state=3 with msg unchanged.
- powerKey and decrementing tick in same cycle -> state=0, msg=0; F2 at 4'd1 decrements to 0 without wrap to 4'd15.

Source files
------------

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: owns the top-level machine state and the
// packed remaining-time message, counting stage fields down on a slow tick.
module wash_sequencer #(
  parameter int SEC_PER_UNIT = 60,
  parameter int FINISH_SEC   = 10
) (
  input  logic        cp,
  input  logic        reset,
  input  logic        tick,
  input  logic        powerKey,
  input  logic        startKey,
  input  logic        fault,
  input  logic [25:0] sourceData,
  output logic [2:0]  state,
  output logic [25:0] msg,
  output logic        motorOn,
  output logic        buzzer
);

  localparam int PW = (SEC_PER_UNIT > 1) ? $clog2(SEC_PER_UNIT) : 1;
  localparam int FW = (FINISH_SEC > 1) ? $clog2(FINISH_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SEC_PER_UNIT - 1);
  localparam logic [FW-1:0] FIN_LAST = FW'(FINISH_SEC - 1);

  typedef enum logic [2:0] {
    SHUTDOWN_ST = 3'd0,
    BEGIN_ST    = 3'd1,
    SET_ST      = 3'd2,
    RUN_ST      = 3'd3,
    ERROR_ST    = 3'd4,
    PAUSE_ST    = 3'd5,
    FINISH_ST   = 3'd6,
    BAD_ST      = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [25:0]   msg_q, msg_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [FW-1:0] fin_q, fin_d;
  logic [25:0]   msg_dec;

  // Decrement the highest-numbered nonzero field only; a zero message stays zero.
  function automatic logic [25:0] dec_active(input logic [25:0] m);
    logic [25:0] r;
    r = m;
    if      (m[25:23] != 3'd0) r[25:23] = m[25:23] - 3'd1;
    else if (m[22:19] != 4'd0) r[22:19] = m[22:19] - 4'd1;
    else if (m[18:16] != 3'd0) r[18:16] = m[18:16] - 3'd1;
    else if (m[15:13] != 3'd0) r[15:13] = m[15:13] - 3'd1;
    else if (m[12:10] != 3'd0) r[12:10] = m[12:10] - 3'd1;
    else if (m[9:6]   != 4'd0) r[9:6]   = m[9:6]   - 4'd1;
    else if (m[5:3]   != 3'd0) r[5:3]   = m[5:3]   - 3'd1;
    else if (m[2:0]   != 3'd0) r[2:0]   = m[2:0]   - 3'd1;
    return r;
  endfunction

  assign msg_dec = dec_active(msg_q);

  always_ff @(posedge cp or posedge reset) begin
    if (reset) begin
      state_q <= SHUTDOWN_ST;
      msg_q   <= '0;
      pre_q   <= '0;
      fin_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      pre_q   <= pre_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    pre_d   = pre_q;
    fin_d   = fin_q;
    if (powerKey) begin
      if (state_q == SHUTDOWN_ST) begin
        state_d = BEGIN_ST;
      end else begin
        state_d = SHUTDOWN_ST;
        msg_d   = '0;
        pre_d   = '0;
        fin_d   = '0;
      end
    end else begin
      case (state_q)
        SHUTDOWN_ST: ;
        BEGIN_ST: begin
          if (startKey) state_d = SET_ST;
        end
        SET_ST: begin
          msg_d = '0;
          if (startKey && (sourceData != 26'd0)) begin
            state_d = RUN_ST;
            msg_d   = sourceData;
            pre_d   = '0;
          end
        end
        RUN_ST: begin
          // fault and pause freeze msg and prescaler so a resume continues mid-unit
          if (fault) begin
            state_d = ERROR_ST;
          end else if (startKey) begin
            state_d = PAUSE_ST;
          end else if (tick) begin
            if (pre_q == PRE_LAST) begin
              pre_d = '0;
              msg_d = msg_dec;
              if (msg_dec == 26'd0) begin
                state_d = FINISH_ST;
                fin_d   = '0;
              end
            end else begin
              pre_d = pre_q + PW'(1);
            end
          end
        end
        PAUSE_ST: begin
          if (fault)         state_d = ERROR_ST;
          else if (startKey) state_d = RUN_ST;
        end
        ERROR_ST: begin
          if (startKey && !fault) state_d = RUN_ST;
        end
        FINISH_ST: begin
          msg_d = '0;
          if (tick) begin
            if (fin_q == FIN_LAST) begin
              state_d = SHUTDOWN_ST;
              fin_d   = '0;
            end else begin
              fin_d = fin_q + FW'(1);
            end
          end
        end
        default: begin
          state_d = SHUTDOWN_ST;
          msg_d   = '0;
          pre_d   = '0;
          fin_d   = '0;
        end
      endcase
    end
  end

  assign state   = state_q;
  assign msg     = msg_q;
  assign motorOn = (state_q == RUN_ST);
  assign buzzer  = (state_q == FINISH_ST) || (state_q == ERROR_ST);

endmodule
